// File: rtl/draw_scheduler_if.sv
// Frame sequencer bundle: frame control, drawer start/done pulses, bus grants.
interface draw_scheduler_if #(
  parameter int NUM_SPRITES = 3
);
  logic                   frame_tick;
  logic [15:0]            map_tile_base;
  logic [NUM_SPRITES-1:0] sprite_enable;
  logic                   map_done;
  logic [NUM_SPRITES-1:0] sprite_done;
  logic                   clear_err;
  logic                   map_draw;
  logic [15:0]            map_tile_address;
  logic [NUM_SPRITES-1:0] sprite_draw;
  logic [NUM_SPRITES:0]   grant;
  logic                   busy;
  logic                   frame_done;
  logic                   overrun;
  logic                   timeout_err;

  modport master (
    input  frame_tick, map_tile_base, sprite_enable,
    input  map_done, sprite_done, clear_err,
    output map_draw, map_tile_address, sprite_draw,
    output grant, busy, frame_done, overrun, timeout_err
  );

  modport slave (
    output frame_tick, map_tile_base, sprite_enable,
    output map_done, sprite_done, clear_err,
    input  map_draw, map_tile_address, sprite_draw,
    input  grant, busy, frame_done, overrun, timeout_err
  );
endinterface

// File: rtl/draw_scheduler.sv
// Per-frame sequencer: map drawer, then enabled sprites, one bus owner at a time.
// Define DRAW_SCHEDULER_TIMEOUT_EN to add the per-drawer watchdog.
module draw_scheduler #(
  parameter int NUM_SPRITES    = 3,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input logic              clk,
  input logic              reset,
  draw_scheduler_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_START_MAP,
    S_WAIT_MAP,
    S_NEXT_SPRITE,
    S_START_SPRITE,
    S_WAIT_SPRITE,
    S_FRAME_DONE
  } state_t;

  localparam int NS = NUM_SPRITES;
  localparam logic [3:0] LAST_IDX = 4'(NUM_SPRITES);
  localparam logic [NS:0] G_MAP = (NS+1)'(1);
  localparam logic [NS-1:0] S_ONE = NS'(1);

  if (NUM_SPRITES < 1 || NUM_SPRITES > 8 ||
      TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 131072) begin : g_cfg_bad
    $error("draw_scheduler: parameter out of range");
  end

  state_t        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [NS-1:0] mask_q, mask_d;
  logic [15:0]   addr_q, addr_d;
  logic          map_draw_q;
  logic [NS-1:0] spr_draw_q, spr_draw_d;
  logic [NS:0]   grant_q, grant_d;
  logic          busy_q;
  logic          fdone_q;
  logic          ovr_q, ovr_d;
  logic [NS-1:0] sel;
  logic          mask_hit;
  logic          done_hit;
  logic          wd_fire;

  // One-hot of the current sprite; empty once idx reaches NUM_SPRITES
  assign sel      = S_ONE << idx_q;
  assign mask_hit = |(mask_q & sel);
  assign done_hit = |(bus.sprite_done & sel);

`ifdef DRAW_SCHEDULER_TIMEOUT_EN
  localparam logic [16:0] TO_LAST = 17'(TIMEOUT_CYCLES - 1);

  logic [16:0] wd_q, wd_d;
  logic        to_q, to_d;
  logic        waiting;

  assign waiting = (state_q == S_WAIT_MAP) ||
                   (state_q == S_WAIT_SPRITE);
  assign wd_fire = waiting && (wd_q == TO_LAST);

  always_comb begin
    wd_d = waiting ? wd_q + 17'd1 : '0;
    to_d = bus.clear_err ? 1'b0 : to_q;
    if (wd_fire) to_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      to_q <= to_d;
    end
  end

  assign bus.timeout_err = to_q;
`else
  assign wd_fire         = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    addr_d  = addr_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.frame_tick) begin
          addr_d  = bus.map_tile_base;
          mask_d  = bus.sprite_enable;
          idx_d   = '0;
          state_d = S_START_MAP;
        end
      end
      S_START_MAP: state_d = S_WAIT_MAP;
      S_WAIT_MAP: begin
        if (bus.map_done || wd_fire) begin
          idx_d   = '0;
          state_d = S_NEXT_SPRITE;
        end
      end
      S_NEXT_SPRITE: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_FRAME_DONE;
        end else if (mask_hit) begin
          state_d = S_START_SPRITE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      S_START_SPRITE: state_d = S_WAIT_SPRITE;
      S_WAIT_SPRITE: begin
        if (done_hit || wd_fire) begin
          idx_d   = idx_q + 4'd1;
          state_d = S_NEXT_SPRITE;
        end
      end
      S_FRAME_DONE: state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_comb begin
    spr_draw_d = '0;
    grant_d    = '0;
    unique case (1'b1)
      (state_q == S_START_MAP),
      (state_q == S_WAIT_MAP):     grant_d = G_MAP;
      (state_q == S_START_SPRITE): begin
        grant_d    = {sel, 1'b0};
        spr_draw_d = sel;
      end
      (state_q == S_WAIT_SPRITE):  grant_d = {sel, 1'b0};
      default:                     grant_d = '0;
    endcase
    ovr_d = bus.clear_err ? 1'b0 : ovr_q;
    if (bus.frame_tick && state_q != S_IDLE) ovr_d = 1'b1;
  end

  // busy tracks the state itself; the other outputs are the
  // registered decode of the state they belong to
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      mask_q     <= '0;
      addr_q     <= '0;
      map_draw_q <= 1'b0;
      spr_draw_q <= '0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      fdone_q    <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      mask_q     <= mask_d;
      addr_q     <= addr_d;
      map_draw_q <= (state_q == S_START_MAP);
      spr_draw_q <= spr_draw_d;
      grant_q    <= grant_d;
      busy_q     <= (state_d != S_IDLE);
      fdone_q    <= (state_q == S_FRAME_DONE);
      ovr_q      <= ovr_d;
    end
  end

  assign bus.map_draw         = map_draw_q;
  assign bus.map_tile_address = addr_q;
  assign bus.sprite_draw      = spr_draw_q;
  assign bus.grant            = grant_q;
  assign bus.busy             = busy_q;
  assign bus.frame_done       = fdone_q;
  assign bus.overrun          = ovr_q;
endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler: frame ordering, latency, overrun,
// stray dones, mid-frame reset and watchdog behaviour.
module tb_draw_scheduler;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  int         r_map, r_fd, r_multi, r_nmap, r_nspr;
  int         r_spr[3];
  logic [3:0] r_gmap;
  logic [3:0] r_gs[3];

  draw_scheduler_if #(.NUM_SPRITES(3)) bus();

  draw_scheduler #(
    .NUM_SPRITES(3),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [27:0] outs();
    return {bus.map_draw, bus.sprite_draw, bus.grant, bus.busy,
            bus.frame_done, bus.overrun, bus.timeout_err,
            bus.map_tile_address};
  endfunction

  task automatic idle_inputs();
    bus.frame_tick    = 1'b0;
    bus.map_tile_base = 16'h0;
    bus.sprite_enable = 3'b000;
    bus.map_done      = 1'b0;
    bus.sprite_done   = 3'b000;
    bus.clear_err     = 1'b0;
  endtask

  // Drives one frame from a tick at cycle 0 with a drawer model that
  // answers each start d cycles later; records event cycles.
  task automatic run_frame(input logic [2:0] en, input int d,
                           input bit stray, input int tick_at,
                           input int clr_at, input int maxc);
    int c, due_m, due_s, s;
    r_map = -1; r_fd = -1; r_multi = 0; r_nmap = 0; r_nspr = 0;
    r_gmap = '0;
    for (int i = 0; i < 3; i++) begin
      r_spr[i] = -1;
      r_gs[i]  = '0;
    end
    c = 0; due_m = -1; due_s = -1; s = 0;
    bus.sprite_enable = en;
    bus.frame_tick    = 1'b1;
    while (r_fd < 0 && c < maxc) begin
      @(posedge clk);
      @(negedge clk);
      c++;
      bus.frame_tick  = 1'b0;
      bus.map_done    = 1'b0;
      bus.sprite_done = 3'b000;
      bus.clear_err   = 1'b0;
      if (c == 1) bus.map_tile_base = ~bus.map_tile_base;
      if ($countones(bus.grant) > 1) r_multi++;
      if (bus.map_draw) begin
        r_map = c; r_nmap++; r_gmap = bus.grant; due_m = c + d;
      end
      for (int i = 0; i < 3; i++) begin
        if (bus.sprite_draw[i]) begin
          r_spr[i] = c; r_gs[i] = bus.grant; r_nspr++;
          s = i; due_s = c + d;
        end
      end
      if (bus.frame_done) r_fd = c;
      if (c == due_m) bus.map_done = 1'b1;
      if (c == due_s) bus.sprite_done[s] = 1'b1;
      if (stray && r_spr[0] >= 0 && c == r_spr[0] + 2) begin
        bus.sprite_done[2] = 1'b1;
        bus.map_done       = 1'b1;
      end
      if (c == tick_at) bus.frame_tick = 1'b1;
      if (c == clr_at) bus.clear_err = 1'b1;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (outs() !== 28'h0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", outs());
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_release_busy got %b want 0", bus.busy);
    end
  endtask

  task automatic test_basic();
    bus.map_tile_base = 16'hBEEF;
    run_frame(3'b101, 10, 1'b0, 0, 0, 200);
    checks++;
    if (r_map !== 2) begin
      errors++; $display("FAIL basic_map_draw got %0d want 2", r_map);
    end
    checks++;
    if (r_gmap !== 4'b0001) begin
      errors++; $display("FAIL basic_map_grant got %b want 0001", r_gmap);
    end
    checks++;
    if (r_spr[0] !== 15) begin
      errors++; $display("FAIL basic_spr0 got %0d want 15", r_spr[0]);
    end
    checks++;
    if (r_spr[1] !== -1) begin
      errors++; $display("FAIL basic_spr1 got %0d want -1", r_spr[1]);
    end
    checks++;
    if (r_spr[2] !== 29) begin
      errors++; $display("FAIL basic_spr2 got %0d want 29", r_spr[2]);
    end
    checks++;
    if (r_gs[0] !== 4'b0010) begin
      errors++; $display("FAIL basic_grant0 got %b want 0010", r_gs[0]);
    end
    checks++;
    if (r_gs[2] !== 4'b1000) begin
      errors++; $display("FAIL basic_grant2 got %b want 1000", r_gs[2]);
    end
    checks++;
    if (r_nspr !== 2) begin
      errors++; $display("FAIL basic_nspr got %0d want 2", r_nspr);
    end
    checks++;
    if (r_fd !== 42) begin
      errors++; $display("FAIL basic_frame_done got %0d want 42", r_fd);
    end
    checks++;
    if (r_multi !== 0) begin
      errors++; $display("FAIL basic_multihot got %0d want 0", r_multi);
    end
    checks++;
    if (bus.map_tile_address !== 16'hBEEF) begin
      errors++;
      $display("FAIL basic_addr got %h want beef", bus.map_tile_address);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL basic_busy_end got %b want 0", bus.busy);
    end
  endtask

  task automatic test_no_sprites();
    bus.map_tile_base = 16'h0042;
    run_frame(3'b000, 5, 1'b0, 0, 0, 200);
    checks++;
    if (r_fd !== 13) begin
      errors++; $display("FAIL nospr_frame_done got %0d want 13", r_fd);
    end
    checks++;
    if (r_nspr !== 0) begin
      errors++; $display("FAIL nospr_draws got %0d want 0", r_nspr);
    end
    checks++;
    if (bus.map_tile_address !== 16'h0042) begin
      errors++;
      $display("FAIL nospr_addr got %h want 0042", bus.map_tile_address);
    end
  endtask

  task automatic test_ignore_stray();
    bus.map_tile_base = 16'h0100;
    run_frame(3'b101, 10, 1'b1, 0, 0, 200);
    checks++;
    if (r_spr[2] !== 29) begin
      errors++; $display("FAIL stray_spr2 got %0d want 29", r_spr[2]);
    end
    checks++;
    if (r_fd !== 42) begin
      errors++; $display("FAIL stray_frame_done got %0d want 42", r_fd);
    end
    checks++;
    if (r_nmap !== 1) begin
      errors++; $display("FAIL stray_nmap got %0d want 1", r_nmap);
    end
  endtask

  task automatic test_back_to_back();
    bus.map_tile_base = 16'h1111;
    run_frame(3'b000, 2, 1'b0, 0, 0, 200);
    checks++;
    if (r_fd !== 10) begin
      errors++; $display("FAIL b2b_first_done got %0d want 10", r_fd);
    end
    bus.map_tile_base = 16'h2222;
    run_frame(3'b111, 1, 1'b0, 0, 0, 200);
    checks++;
    if (r_spr[0] !== 6 || r_spr[1] !== 10 || r_spr[2] !== 14) begin
      errors++;
      $display("FAIL b2b_sprites got %0d %0d %0d want 6 10 14",
               r_spr[0], r_spr[1], r_spr[2]);
    end
    checks++;
    if (r_fd !== 18) begin
      errors++; $display("FAIL b2b_second_done got %0d want 18", r_fd);
    end
    checks++;
    if (bus.map_tile_address !== 16'h2222) begin
      errors++;
      $display("FAIL b2b_addr got %h want 2222", bus.map_tile_address);
    end
    checks++;
    if (bus.overrun !== 1'b0) begin
      errors++; $display("FAIL b2b_overrun got %b want 0", bus.overrun);
    end
  endtask

  task automatic test_overrun();
    int n;
    run_frame(3'b001, 10, 1'b0, 20, 0, 200);
    checks++;
    if (r_fd !== 30) begin
      errors++; $display("FAIL ovr_frame_done got %0d want 30", r_fd);
    end
    checks++;
    if (bus.overrun !== 1'b1) begin
      errors++; $display("FAIL ovr_set got %b want 1", bus.overrun);
    end
    n = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.busy || bus.map_draw) n++;
    end
    checks++;
    if (n !== 0) begin
      errors++; $display("FAIL ovr_dropped_tick got %0d want 0", n);
    end
    bus.clear_err = 1'b1;
    @(negedge clk);
    bus.clear_err = 1'b0;
    checks++;
    if (bus.overrun !== 1'b0) begin
      errors++; $display("FAIL ovr_clear got %b want 0", bus.overrun);
    end
    run_frame(3'b000, 2, 1'b0, 4, 4, 200);
    checks++;
    if (bus.overrun !== 1'b1) begin
      errors++; $display("FAIL ovr_set_wins got %b want 1", bus.overrun);
    end
    bus.clear_err = 1'b1;
    @(negedge clk);
    bus.clear_err = 1'b0;
    checks++;
    if (bus.overrun !== 1'b0) begin
      errors++; $display("FAIL ovr_clear2 got %b want 0", bus.overrun);
    end
  endtask

  task automatic test_watchdog();
    run_frame(3'b000, 1000, 1'b0, 0, 0, 40);
`ifdef DRAW_SCHEDULER_TIMEOUT_EN
    checks++;
    if (r_fd !== 23) begin
      errors++; $display("FAIL wd_frame_done got %0d want 23", r_fd);
    end
    checks++;
    if (bus.timeout_err !== 1'b1) begin
      errors++; $display("FAIL wd_flag got %b want 1", bus.timeout_err);
    end
    bus.clear_err = 1'b1;
    @(negedge clk);
    bus.clear_err = 1'b0;
    checks++;
    if (bus.timeout_err !== 1'b0) begin
      errors++; $display("FAIL wd_clear got %b want 0", bus.timeout_err);
    end
`else
    checks++;
    if (r_fd !== -1) begin
      errors++; $display("FAIL nowd_frame_done got %0d want -1", r_fd);
    end
    checks++;
    if (bus.busy !== 1'b1 || bus.grant !== 4'b0001) begin
      errors++;
      $display("FAIL nowd_stuck got busy %b grant %b want 1 0001",
               bus.busy, bus.grant);
    end
    checks++;
    if (bus.timeout_err !== 1'b0) begin
      errors++; $display("FAIL nowd_flag got %b want 0", bus.timeout_err);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
`endif
  endtask

  task automatic test_reset_mid();
    int n;
    bus.map_tile_base = 16'h1234;
    bus.sprite_enable = 3'b111;
    bus.frame_tick    = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.grant !== 4'b0001) begin
      errors++; $display("FAIL rmid_pre_grant got %b want 0001", bus.grant);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (outs() !== 28'h0) begin
      errors++; $display("FAIL rmid_async_outputs got %h want 0", outs());
    end
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      bus.map_done    = (i == 2);
      bus.sprite_done = (i == 4) ? 3'b111 : 3'b000;
      @(negedge clk);
      if (bus.busy || bus.map_draw || bus.frame_done ||
          bus.sprite_draw != 3'b000 || bus.grant != 4'b0000) n++;
    end
    bus.map_done    = 1'b0;
    bus.sprite_done = 3'b000;
    checks++;
    if (n !== 0) begin
      errors++; $display("FAIL rmid_no_resume got %0d want 0", n);
    end
    bus.map_tile_base = 16'h5678;
    run_frame(3'b000, 1, 1'b0, 0, 0, 200);
    checks++;
    if (r_fd !== 9) begin
      errors++; $display("FAIL rmid_fresh_done got %0d want 9", r_fd);
    end
    checks++;
    if (bus.map_tile_address !== 16'h5678) begin
      errors++;
      $display("FAIL rmid_addr got %h want 5678", bus.map_tile_address);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_sprites();
    test_ignore_stray();
    test_back_to_back();
    test_overrun();
    test_watchdog();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/draw_scheduler.md
DRAW_SCHEDULER -- requirements
Module: draw_scheduler

Interface
REQ-001 Parameter NUM_SPRITES, default 3, meaning the number of sprite drawer requesters (1..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 100000, meaning the watchdog limit per drawer, in clk cycles (17-bit counter).
REQ-003 Clocking SHALL be one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  system clock.
REQ-005 reset  in  1  asynchronous active-high reset.
REQ-006 frame_tick  in  1  single-cycle pulse marking frame start.
REQ-007 map_tile_base  in  16  ROM base address for the background map.
REQ-008 sprite_enable  in  NUM_SPRITES  per-sprite draw request for this frame.
REQ-009 map_done  in  1  map drawer completion pulse.
REQ-010 sprite_done  in  NUM_SPRITES  per-sprite drawer completion pulses.
REQ-011 clear_err  in  1  clears the sticky error flags.
REQ-012 map_draw  out  1  one-cycle start pulse to the map drawer.
REQ-013 map_tile_address  out  16  latched tile base presented to the map drawer.
REQ-014 sprite_draw  out  NUM_SPRITES  one-hot, one-cycle sprite start pulse.
REQ-015 grant  out  NUM_SPRITES+1  one-hot owner of the shared ROM/VGA buses; bit 0 = map, bit i+1 = sprite i.
REQ-016 busy  out  1  high whenever the state is not S_IDLE.
REQ-017 frame_done  out  1  one-cycle pulse at the end of the frame sequence.
REQ-018 overrun  out  1  sticky flag: frame_tick arrived while busy.
REQ-019 timeout_err  out  1  sticky watchdog flag.

Function
REQ-020 The FSM states SHALL be S_IDLE, S_START_MAP, S_WAIT_MAP, S_NEXT_SPRITE, S_START_SPRITE, S_WAIT_SPRITE and S_FRAME_DONE, all with registered outputs.
REQ-021 In S_IDLE, a frame_tick SHALL latch map_tile_base into map_tile_address and sprite_enable into an internal mask, and SHALL move to S_START_MAP on the next cycle.
REQ-022 S_START_MAP SHALL assert map_draw and grant[0] for exactly one cycle, then move to S_WAIT_MAP.
REQ-023 S_WAIT_MAP SHALL hold grant[0] until map_done is sampled high, then clear the sprite index to 0 and move to S_NEXT_SPRITE.
REQ-024 S_NEXT_SPRITE SHALL behave as follows: if index == NUM_SPRITES, go to S_FRAME_DONE; else if mask[index] = 1, go to S_START_SPRITE; otherwise increment index and stay (1 cycle per skipped sprite).
REQ-025 S_START_SPRITE SHALL assert sprite_draw[index] and grant[index+1] for one cycle, then move to S_WAIT_SPRITE.
REQ-026 S_WAIT_SPRITE SHALL hold grant[index+1] until sprite_done[index] is sampled high, then increment index and return to S_NEXT_SPRITE.
REQ-027 S_FRAME_DONE SHALL pulse frame_done for one cycle with grant = 0, then return to S_IDLE.
REQ-028 grant SHALL be all-zero in S_IDLE, S_NEXT_SPRITE and S_FRAME_DONE, and never have more than one bit set.
REQ-029 Done pulses from a requester that is not currently granted SHALL be ignored.
REQ-030 A frame_tick while busy SHALL be dropped and SHALL set overrun; if clear_err occurs in the same cycle, set wins.
REQ-031 clear_err SHALL clear overrun and timeout_err on the next edge.
REQ-032 Minimum frame latency with all sprites disabled SHALL be frame_tick -> frame_done = 4 + NUM_SPRITES cycles plus the map drawer time.

Reset
REQ-033 Reset SHALL force state S_IDLE, index 0, mask 0, map_tile_address 0, and every output to 0, asynchronously, including mid-frame.
REQ-034 After reset deasserts, the block SHALL wait for a fresh frame_tick; an interrupted frame SHALL NOT resume.

Configuration
REQ-035 With macro DRAW_SCHEDULER_TIMEOUT_EN defined, a watchdog SHALL be included, as follows:
- Counter clears on entry to S_WAIT_MAP/S_WAIT_SPRITE and increments each wait cycle.
- At TIMEOUT_CYCLES-1 the scheduler sets timeout_err, releases grant, and advances as if done was received.
REQ-036 Without DRAW_SCHEDULER_TIMEOUT_EN, the watchdog logic SHALL be absent, timeout_err SHALL be tied 0, and the wait states SHALL wait indefinitely.

Verification
REQ-037 frame_tick, sprite_enable=3'b101, all done pulses 10 cycles after start -> pulse order map_draw, sprite_draw=001, sprite_draw=100, then frame_done; grant never multi-hot.
REQ-038 frame_tick with sprite_enable=0, map_done 5 cycles after map_draw -> frame_done exactly 3+3 cycles after map_done; no sprite_draw.
REQ-039 frame_tick during S_WAIT_SPRITE -> ignored, overrun=1; later clear_err -> overrun=0.
REQ-040 sprite_done[2] pulsed while grant[1] is active -> no state change.
REQ-041 Reset asserted mid-S_WAIT_MAP -> all outputs 0 immediately; no activity until the next frame_tick.
REQ-042 With the macro defined and TIMEOUT_CYCLES=16, map_done withheld -> timeout_err=1 at cycle 16 of the wait, then the scheduler proceeds to the sprites; without the macro, the scheduler stays in S_WAIT_MAP.
